// File: rtl/gpr_dump_if.sv
// Valid/ready beat channel that carries one {index, value} pair per transfer
// from the dump engine to its consumer.
interface gpr_dump_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;

  modport master (
    output dump_valid, dump_addr, dump_data, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_addr, dump_data, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/gpr_dump.sv
// Debug read-out engine: freezes the CPU, walks a wrapping register index range
// through the register file read port and streams {index, value} beats out.
module gpr_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_reg,
  input  logic [AW-1:0] last_reg,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  gpr_dump_if.master    dump,
  output logic          busy,
  output logic          hold_cpu,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] csum_q;
  logic          valid_q, last_flag_q, busy_q, done_q;

  // Index wraps at NREG, which need not be a power of two.
  assign ptr_d = (ptr_q == AW'(NREG - 1)) ? '0 : ptr_q + 1'b1;

  // NOTE: one always_ff with non-blocking assignments owns every state bit; the
  // async reset branch clears them all so outputs drop the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      csum_q      <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= first_reg;
            last_q  <= last_reg;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          data_q      <= rd_data;
          addr_q      <= ptr_q;
          last_flag_q <= (ptr_q == last_q);
          valid_q     <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (valid_q && dump.dump_ready) begin
            csum_q  <= csum_q ^ data_q;
            valid_q <= 1'b0;
            if (last_flag_q) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              ptr_q   <= ptr_d;
              state_q <= LOAD;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_addr         = ptr_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_addr  = addr_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_flag_q;
  assign busy            = busy_q;
  assign hold_cpu        = busy_q;
  assign done            = done_q;
  assign checksum        = csum_q;

endmodule

// File: tb/tb_gpr_dump.sv
// Self-checking bench for gpr_dump: a transaction-level model predicts every
// beat, status bit and checksum, and is cross-checked by hand-computed results.
module tb_gpr_dump;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst, start, ready;
  logic [AW-1:0] first_reg, last_reg, rd_addr;
  logic [DW-1:0] rd_data, checksum;
  logic          busy, hold_cpu, done;
  logic [DW-1:0] regs [NREG];

  gpr_dump_if #(.AW(AW), .DW(DW)) dif ();

  assign dif.dump_ready = ready;
  assign rd_data        = regs[rd_addr];

  always #5 clk = ~clk;

  gpr_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dump      (dif),
    .busy      (busy),
    .hold_cpu  (hold_cpu),
    .done      (done),
    .checksum  (checksum)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  int      checks = 0;
  int      errors = 0;
  int      rmode  = 0;      // 0: ready held by driver, 1: random ready each cycle
  beat_t   exp_q[$];
  int      acc_log[$];
  logic [DW-1:0] m_csum;
  bit      m_busy, m_load, m_valid, m_fin;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_csum  = '0;
    m_busy  = 0;
    m_load  = 0;
    m_valid = 0;
    m_fin   = 0;
  endtask

  // Reference model: a dump is the list of indices first, first+1, ... (mod NREG)
  // up to last; each beat appears one cycle after its read and costs one more
  // cycle per stalled handshake; done follows the final handshake.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) begin
        model_reset();
      end else if (m_fin) begin
        m_fin  = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          int cnt;
          cnt = ((int'(last_reg) - int'(first_reg) + NREG) % NREG) + 1;
          for (int i = 0; i < cnt; i++) begin
            int idx;
            idx = (int'(first_reg) + i) % NREG;
            exp_q.push_back('{a: AW'(idx), d: regs[idx], l: (i == cnt - 1)});
          end
          m_csum = '0;
          m_busy = 1;
          m_load = 1;
        end
      end else if (m_valid) begin
        if (ready) begin
          m_csum  = m_csum ^ exp_q[0].d;
          acc_log.push_back(int'(exp_q[0].a));
          m_fin   = exp_q[0].l;
          m_load  = !exp_q[0].l;
          m_valid = 0;
          void'(exp_q.pop_front());
        end
      end else if (m_load) begin
        m_load  = 0;
        m_valid = 1;
      end

      @(negedge clk);
      if (!rst) model_reset();
      check("valid", 32'(dif.dump_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_busy));
      check("hold_cpu", 32'(hold_cpu), 32'(m_busy));
      check("done", 32'(done), 32'(m_fin));
      check("checksum", checksum, m_csum);
      if (m_valid && exp_q.size() > 0) begin
        check("dump_addr", 32'(dif.dump_addr), 32'(exp_q[0].a));
        check("dump_data", dif.dump_data, exp_q[0].d);
        check("dump_last", 32'(dif.dump_last), 32'(exp_q[0].l));
      end
      if (m_busy && m_load && exp_q.size() > 0)
        check("rd_addr", 32'(rd_addr), 32'(exp_q[0].a));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (rmode == 1) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input int f, input int l);
    first_reg = AW'(f);
    last_reg  = AW'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen;
    seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_beat(input int addr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (dif.dump_valid && int'(dif.dump_addr) == addr) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("beat_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_log(input string name, input int exp_addrs[$]);
    check({name, "_len"}, 32'(acc_log.size()), 32'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < acc_log.size(); i++)
      check({name, "_addr"}, 32'(acc_log[i]), 32'(exp_addrs[i]));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({name, "_valid"}, 32'(dif.dump_valid), 32'd0);
    check({name, "_addr"}, 32'(dif.dump_addr), 32'd0);
    check({name, "_data"}, dif.dump_data, 32'd0);
    check({name, "_last"}, 32'(dif.dump_last), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_hold"}, 32'(hold_cpu), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_csum"}, checksum, 32'd0);
  endtask

  initial begin
    int n;
    int exp_wrap[$];
    int exp_one[$];
    int exp_full[$];
    exp_wrap = '{30, 31, 0, 1, 2};
    exp_one  = '{5};
    for (int i = 0; i < NREG; i++) exp_full.push_back(i);

    rst = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; ready = 1'b1;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + DW'(i);
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Single word
    acc_log.delete();
    do_start(5, 5);
    wait_done(n);
    check("s1_csum", checksum, 32'h1005);
    check("s1_busy_cycles", 32'(n), 32'd3);
    check_log("s1", exp_one);
    repeat (3) tick();
    check("s1_csum_hold", checksum, 32'h1005);

    // Full dump
    acc_log.delete();
    do_start(0, 31);
    wait_done(n);
    check("s2_busy_cycles", 32'(n), 32'd65);
    check("s2_csum", checksum, 32'h0);
    check_log("s2", exp_full);
    tick();

    // Wrap-around
    acc_log.delete();
    do_start(30, 2);
    wait_done(n);
    check("s3_csum", checksum, 32'h1002);
    check_log("s3", exp_wrap);
    tick();

    // Backpressure on the second beat
    acc_log.delete();
    do_start(30, 2);
    wait_beat(31);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s4_stall_addr", 32'(dif.dump_addr), 32'd31);
      check("s4_stall_data", dif.dump_data, 32'h101F);
      check("s4_stall_csum", checksum, 32'h101E);
    end
    ready = 1'b1;
    wait_done(n);
    check("s4_csum", checksum, 32'h1002);
    check_log("s4", exp_wrap);
    tick();

    // Start while busy
    acc_log.delete();
    do_start(30, 2);
    repeat (3) tick();
    first_reg = AW'(9);
    last_reg  = AW'(9);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(n);
    check("s6_csum", checksum, 32'h1002);
    check_log("s6", exp_wrap);
    tick();

    // Reset mid-SEND, then restart
    do_start(0, 31);
    wait_beat(10);
    rst = 1'b0;
    #1;
    check_all_zero("s5_async");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("s5_no_resume", 32'(busy), 32'd0);
    acc_log.delete();
    do_start(5, 5);
    wait_done(n);
    check("s5_csum", checksum, 32'h1005);
    check_log("s5", exp_one);
    tick();

    // Randomized ranges, data and backpressure
    rmode = 1;
    for (int it = 0; it < 24; it++) begin
      int f, l, cnt;
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      f = $urandom_range(0, NREG - 1);
      l = $urandom_range(0, NREG - 1);
      if (it == 0) l = (f + NREG - 1) % NREG;
      if (it == 1) l = f;
      cnt = ((l - f + NREG) % NREG) + 1;
      acc_log.delete();
      do_start(f, l);
      wait_done(n);
      check("rnd_beats", 32'(acc_log.size()), 32'(cnt));
      tick();
    end
    rmode = 0;
    ready = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
